// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one combinational-read memory between the fetch
// (I, read-only) and memory-stage (D, read/write) requesters. One access is
// granted per cycle, D has priority, and a saturating starvation counter
// forces an I grant after MAX_WAIT consecutive denials. Read data is
// registered and returned with a one-cycle rvalid pulse; accesses that run
// past MEM_BYTES are still granted but flagged, with writes suppressed and
// read data forced to zero.
module mem_port_arbiter #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_BYTES  = 56,
    parameter int MAX_WAIT   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,

    // fetch port
    input  logic                     i_req,
    input  logic [ADDR_WIDTH-1:0]    i_addr,
    output logic                     i_gnt,
    output logic                     i_rvalid,
    output logic [8*BYTE_SIZE-1:0]   i_rdata,
    output logic                     i_err,

    // data port
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDR_WIDTH-1:0]    d_addr,
    input  logic [8*BYTE_SIZE-1:0]   d_wdata,
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [8*BYTE_SIZE-1:0]   d_rdata,
    output logic                     d_err,

    // memory side
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [8*BYTE_SIZE-1:0]   mem_wd,
    input  logic [8*BYTE_SIZE-1:0]   mem_rd
);

    // Range limits held one bit wider than the address so addr + BYTE_SIZE
    // cannot wrap back into range.
    localparam logic [ADDR_WIDTH:0] ACC_BYTES = (ADDR_WIDTH+1)'(BYTE_SIZE);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [3:0]          WAIT_MAX  = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_I    = 2'd1,
        SEL_D    = 2'd2
    } sel_t;

    sel_t                   sel;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [ADDR_WIDTH-1:0]  last_addr;
    logic                   i_oor;
    logic                   d_oor;
    logic [3:0]             wait_cnt;
    logic [3:0]             wait_nxt;
    logic                   force_i;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (({1'b0, a} + ACC_BYTES) > MEM_LIMIT);
    endfunction

    assign i_oor = out_of_range(i_addr);
    assign d_oor = out_of_range(d_addr);

    // Arbitration: forced fetch first, then D, then I; nothing during reset.
    always_comb begin
        sel = SEL_NONE;
        if (rst_n) begin
            if (force_i && i_req) begin
                sel = SEL_I;
            end else if (d_req) begin
                sel = SEL_D;
            end else if (i_req) begin
                sel = SEL_I;
            end
        end
    end

    assign i_gnt = (sel == SEL_I);
    assign d_gnt = (sel == SEL_D);

    // Address mux: winner's address, or the last granted address when idle.
    always_comb begin
        sel_addr = last_addr;
        case (sel)
            SEL_I:   sel_addr = i_addr;
            SEL_D:   sel_addr = d_addr;
            default: sel_addr = last_addr;
        endcase
    end

    assign mem_addr = sel_addr;
    assign mem_wd   = d_wdata;
    assign mem_we   = d_gnt & d_we & ~d_oor;

    // Remember the most recent granted address for idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr <= '0;
        end else if (sel != SEL_NONE) begin
            last_addr <= sel_addr;
        end
    end

    // Fetch response: one-cycle valid pulse, data held between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            i_rdata  <= '0;
        end else begin
            i_rvalid <= i_gnt;
            i_err    <= i_gnt & i_oor;
            if (i_gnt) begin
                i_rdata <= i_oor ? '0 : mem_rd;
            end
        end
    end

    // Data response: writes and out-of-range reads return zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            d_rvalid <= d_gnt;
            d_err    <= d_gnt & d_oor;
            if (d_gnt) begin
                d_rdata <= (d_we || d_oor) ? '0 : mem_rd;
            end
        end
    end

    // Next starvation count: saturating increment on denial, else clear.
    always_comb begin
        wait_nxt = '0;
        if (i_req && !i_gnt) begin
            wait_nxt = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
        end
    end

    // Starvation state: force_i raised once the count reaches MAX_WAIT and
    // held until the fetch is actually granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            force_i  <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (i_gnt) begin
                force_i <= 1'b0;
            end else if (wait_nxt >= WAIT_MAX) begin
                force_i <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable, little-endian data/instruction memory between two requesters: the fetch stage (I port, read-only) and the memory stage (D port, read/write).
- Grants one access per cycle and drives the memory's address, write-data and write-enable inputs.
- Registers the combinational memory read data and returns it with a one-cycle valid pulse.
- Detects out-of-range accesses.
- D has priority; a starvation counter guarantees fetch progress.

Parameters:
- BYTE_SIZE, 4, access width in bytes (data width = 8*BYTE_SIZE)
- ADDR_WIDTH, 12, byte-address width
- MEM_BYTES, 56, implemented memory depth in bytes; accesses beyond it are errors
- MAX_WAIT, 3, consecutive I-port denials after which I wins the next arbitration (range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_WIDTH  fetch byte address
- i_gnt  out  1  fetch granted this cycle (combinational)
- i_rvalid  out  1  i_rdata/i_err valid (registered pulse)
- i_rdata  out  8*BYTE_SIZE  fetched word
- i_err  out  1  granted fetch was out of range
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  8*BYTE_SIZE  write data
- d_gnt  out  1  data access granted this cycle (combinational)
- d_rvalid  out  1  d_rdata/d_err valid (registered pulse; reads and writes)
- d_rdata  out  8*BYTE_SIZE  read word (0 for writes)
- d_err  out  1  granted data access was out of range
- mem_we  out  1  to memory write enable
- mem_addr  out  ADDR_WIDTH  to memory address
- mem_wd  out  8*BYTE_SIZE  to memory write data
- mem_rd  in  8*BYTE_SIZE  from memory combinational read data

Behaviour:
- Reset: while rst_n=0, the following are all 0:
  - registered outputs: i_rvalid, i_rdata, i_err, d_rvalid, d_rdata, d_err
  - wait counter and force_i flag
  - i_gnt, d_gnt and mem_we, gated by rst_n
- Reset asserted mid-operation: any pending rvalid pulse is dropped and no write reaches memory. Requesters re-present their requests after reset.
- Arbitration (combinational, each cycle):
  - force_i=1 and i_req=1: I wins.
  - Otherwise d_req=1: D wins.
  - Otherwise i_req=1: I wins.
  - Otherwise idle.
- Exactly one of i_gnt or d_gnt may be high per cycle.
- Memory drive:
  - mem_addr = winner's address; when idle, mem_addr holds its previous value (registered last address).
  - mem_wd = d_wdata.
  - mem_we = d_gnt & d_we & ~range_err.
- Range check: range_err = (addr + BYTE_SIZE > MEM_BYTES), computed at ADDR_WIDTH+1 bits to avoid wrap. On a range error:
  - the access is still granted, so the requester never hangs;
  - writes are suppressed and reads return 0;
  - the err bit is set together with rvalid.
- Latency:
  - A grant in cycle N produces rvalid=1 in cycle N+1 for exactly one cycle, with rdata = mem_rd sampled at the end of cycle N (D writes return rdata=0).
  - A write commits at the rising edge ending cycle N.
  - A read in cycle N+1 of the same address therefore returns the new data.
  - Back-to-back grants yield back-to-back rvalid pulses.
  - rdata holds its last value when rvalid=0.
- Starvation counter (4 bits, saturating):
  - Increments on each cycle with i_req=1 and i_gnt=0.
  - Clears on i_gnt or when i_req=0.
  - force_i is set when the counter reaches MAX_WAIT and clears on i_gnt.
- Simultaneous requests with force_i=0: D wins and the I counter increments.
- Protocol violation (request dropped before grant): no requirement beyond no spurious grant, rvalid or write.

Test Plan:
- Reset then idle (i_req=d_req=0): all outputs 0; mem_we never 1.
- D write 0xDEADBEEF to addr 0x008, then D read of 0x008 next cycle: mem_we high for one cycle; d_rvalid follows each grant by 1 cycle; read returns d_rdata=0xDEADBEEF with d_err=0.
- I read of addr 0x004 alone, memory bytes 4..7 = 01 02 03 04: i_gnt same cycle, next cycle i_rvalid=1 and i_rdata=0x04030201.
- i_req and d_req both held continuously with MAX_WAIT=3: grants D,D,D,I, repeating; i_rvalid every 4th cycle.
- D write to addr 0x035 (53+4>56): d_gnt=1, mem_we=0, next cycle d_rvalid=1 and d_err=1; memory bytes 52..55 unchanged. D read of addr 0x034 returns d_err=0.
- Assert rst_n=0 in the cycle after a D read grant: d_rvalid stays 0, counter cleared; after release, a fresh I read completes normally.
